// File: rtl/hcv_fill.sv
// hcv_fill: rectangle fill engine for the 1024x768 high-color frame buffer.
// CPU-programmed origin/size/color; issues one 16-bit pixel write per frame-buffer transaction.
module hcv_fill (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stb,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  output logic        m_stb,
  output logic        m_we,
  output logic [19:0] m_addr,
  output logic [31:0] m_data,
  input  logic        m_ack
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]  state;
  logic [9:0]  x0, y0;
  logic [10:0] w;
  logic [9:0]  h;
  logic [14:0] color;
  logic [9:0]  x, y;
  logic [10:0] col;
  logic [9:0]  row;
  logic        done;
  logic        abort_flag;
  logic        busy;

  logic wr, wr_ctrl, start_req, clr_done, abort_req;
  logic size_zero, col_more, row_more;
  logic unused_data_bits;

  assign busy      = (state != ST_IDLE);
  assign ack       = stb;
  assign m_we      = m_stb;
  assign wr        = stb & we;
  assign wr_ctrl   = wr & (addr == 2'd3);
  assign start_req = wr_ctrl & data_in[0];
  assign clr_done  = wr_ctrl & data_in[1];
  assign abort_req = wr_ctrl & data_in[2];
  assign size_zero = (w == 11'd0) || (h == 10'd0);
  assign col_more  = (col + 11'd1) < w;
  assign row_more  = (row + 10'd1) < h;
  assign unused_data_bits = ^{data_in[31:26], data_in[15]};

  // Geometry and color are frozen for the duration of a fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0    <= '0;
      y0    <= '0;
      w     <= '0;
      h     <= '0;
      color <= '0;
    end else if (wr && !busy) begin
      case (addr)
        2'd0: begin
          x0 <= data_in[9:0];
          y0 <= data_in[25:16];
        end
        2'd1: begin
          w <= data_in[10:0];
          h <= data_in[25:16];
        end
        2'd2: color <= data_in[14:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    data_out = '0;
    case (addr)
      2'd0:    data_out = {6'b0, y0, 6'b0, x0};
      2'd1:    data_out = {6'b0, h, 5'b0, w};
      2'd2:    data_out = {17'b0, color};
      default: data_out = {30'b0, done, busy};
    endcase
  end

  // GAP keeps m_stb low for one cycle so the controller's second ack cycle is absorbed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      done       <= 1'b0;
      abort_flag <= 1'b0;
      m_stb      <= 1'b0;
      m_addr     <= '0;
      m_data     <= '0;
      x          <= '0;
      y          <= '0;
      col        <= '0;
      row        <= '0;
    end else begin
      if (clr_done)
        done <= 1'b0;
      if (abort_req && busy)
        abort_flag <= 1'b1;
      case (state)
        ST_IDLE: begin
          abort_flag <= 1'b0;
          if (start_req) begin
            if (size_zero) begin
              done <= 1'b1;
            end else begin
              done   <= 1'b0;
              state  <= ST_REQ;
              x      <= x0;
              y      <= y0;
              col    <= '0;
              row    <= '0;
              m_stb  <= 1'b1;
              m_addr <= {y0, x0};
              m_data <= {17'b0, color};
            end
          end
        end
        ST_REQ: begin
          if (m_ack) begin
            state <= ST_GAP;
            m_stb <= 1'b0;
          end
        end
        ST_GAP: begin
          if (abort_flag) begin
            state      <= ST_IDLE;
            done       <= 1'b1;
            abort_flag <= 1'b0;
          end else if (col_more) begin
            col    <= col + 11'd1;
            x      <= x + 10'd1;
            m_addr <= {y, x + 10'd1};
            m_stb  <= 1'b1;
            state  <= ST_REQ;
          end else if (row_more) begin
            col    <= '0;
            x      <= x0;
            row    <= row + 10'd1;
            y      <= y + 10'd1;
            m_addr <= {y + 10'd1, x0};
            m_stb  <= 1'b1;
            state  <= ST_REQ;
          end else begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/hcv_fill.md
# hcv_fill

Rectangle fill engine for the 1024x768 high-color frame buffer. The CPU programs origin, size and color through a small register port and starts a fill. The block then acts as bus initiator toward the frame-buffer bus port of the video controller, issuing one 16-bit write per pixel. It waits for each acknowledge and spaces transactions so that the controller's two-cycle ack never triggers a duplicate write.

## Interface
Parameters:
- none (frame-buffer geometry fixed: pixel address = {y[9:0], x[9:0]}, color 5:5:5 in bits 14:0)

Ports:
- clk  in  1  system clock; same clock as the video controller's frame-buffer port
- rst_n  in  1  reset; asynchronous assert, active-low
- stb  in  1  register access strobe (CPU side)
- we  in  1  register write enable
- addr  in  2  register index
- data_in  in  32  register write data
- data_out  out  32  register read data
- ack  out  1  register access ack, combinational = stb
- m_stb  out  1  frame-buffer request (registered)
- m_we  out  1  frame-buffer write enable, always equal to m_stb
- m_addr  out  20  frame-buffer pixel address (registered)
- m_data  out  32  write data: {16'h0000, 1'b0, color[14:0]}
- m_ack  in  1  frame-buffer ack from the video controller

## Operation
Registers (reads and writes are zero-wait; ack = stb in the same cycle):
- 0 ORG: x0 in [9:0], y0 in [25:16]
- 1 SIZE: w in [10:0] (0..1024), h in [25:16] (0..1023)
- 2 COLOR: color in [14:0]
- 3 CTRL/STATUS:
  - Write: bit0 = start, bit1 = clear done, bit2 = abort.
  - Read: bit0 = busy, bit1 = done.
  - Unused read bits are 0.
- Writes to regs 0-2 while busy are ignored; reads always return the current register values.
- Start while busy is ignored. Start with w = 0 or h = 0 sets done at once and issues no transaction.
- Start and clear done in the same write: start wins, and done is cleared.

States: IDLE, REQ, GAP.
- IDLE + start (w, h nonzero):
  - Load x = x0, y = y0, col = 0, row = 0.
  - Set busy, clear done, go to REQ.
  - Drive m_stb = 1 with m_addr = {y0, x0}.
- REQ: hold m_stb, m_addr and m_data stable until m_ack = 1. On that cycle go to GAP and drop m_stb in the next cycle.
- GAP: m_stb = 0 for exactly one cycle, which absorbs the trailing second ack cycle. Then advance the counters:
  - col + 1 < w: col += 1, x = x + 1 (mod 1024), back to REQ.
  - Otherwise, if row + 1 < h: col = 0, x = x0, row += 1, y = y + 1 (mod 1024), back to REQ.
  - Otherwise: go to IDLE, clear busy, set done.
- Abort: sets an abort flag.
  - In REQ, the current write completes.
  - In GAP, the flag forces the IDLE exit with done set, regardless of the counters.
- Wrap-around: x and y wrap mod 1024 with no clipping. Rows 768-1023 are written to off-screen memory.
- m_ack outside REQ is ignored.

Reset values (asynchronous, all to 0): state IDLE, busy, done, abort flag, ORG, SIZE, COLOR, m_stb, m_we, m_addr, m_data.

## Timing
- Start write in cycle t → m_stb = 1 from cycle t+1.
- Against the video controller, m_ack is high in cycles t+4 and t+5 of each transaction.
- m_stb falls in cycle t+5; GAP is t+5; the next m_stb is in cycle t+6.
- Per pixel: 5 cycles. A w×h fill takes 5·w·h cycles from first m_stb to done.
- done/busy update the cycle after the final GAP.
- m_ack held high continuously still yields exactly one write per pixel, because GAP forces m_stb low.

## Test plan
- Reset with rst_n low mid-fill (in REQ) → all outputs 0 immediately, busy = 0, no further m_stb after release.
- ORG = (10, 5), SIZE = 2×2, COLOR = 0x7C00, start, with a video controller ack model:
  - writes to 0x0140A, 0x0140B, 0x0180A, 0x0180B, each with m_data 0x00007C00;
  - exactly 4 m_stb rising edges;
  - done after 20 cycles.
- SIZE w = 0, start → no m_stb; STATUS reads 0x2 on the next cycle.
- ORG = (1023, 1023), SIZE = 2×2 → addresses 0xFFFFF, 0xFFC00, 0x003FF, 0x00000 (wrap).
- Abort written while in REQ of pixel 3 of a 4×1 fill → pixel 3 write completes, pixel 4 is never issued, STATUS = 0x2.
- Write COLOR during busy → m_data unchanged; read COLOR returns the old value. Start during busy → no restart.
